// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full-subtractor cell plus a borrow flop,
// WIDTH cycles per operation, with borrow/overflow/zero flags.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             bw;
    logic             bw_next;
    logic             d;
    logic             a_msb;
    logic             b_msb;
    logic             accept;
    logic             last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the full-subtractor cell on the current LSBs
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        d          = sa[0] ^ sb[0] ^ bw;
        bw_next    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
        sr_next    = {d, sr[WIDTH-1:1]};
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            sa             <= '0;
            sb             <= '0;
            sr             <= '0;
            bw             <= 1'b0;
            a_msb          <= 1'b0;
            b_msb          <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.zero       <= 1'b0;
        end else begin
            bus.busy <= (next_state == RUN);
            bus.done <= (next_state == DONE);
            if (accept) begin
                sa    <= bus.a;
                sb    <= bus.b;
                sr    <= '0;
                bw    <= 1'b0;
                cnt   <= '0;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                sr  <= sr_next;
                bw  <= bw_next;
                cnt <= cnt + CNT_W'(1);
            end
            // Results move only on the final bit, so they hold through RUN
            if (last) begin
                bus.diff       <= sr_next;
                bus.borrow_out <= bw_next;
                bus.zero       <= (sr_next == '0);
                bus.overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
            end
        end
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell plus a borrow flip-flop, giving the inverse operation of the team's 1-bit full adder.
- Sits in the datapath as a low-area multi-cycle ALU unit with a start/busy/done handshake.
- Also reports unsigned borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on the rising edge while not busy
- a  input  WIDTH  minuend; sampled only on the accepting edge
- b  input  WIDTH  subtrahend; sampled only on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow_out  output  1  1 when a < b (unsigned)
- overflow  output  1  signed two's-complement overflow of a - b
- zero  output  1  1 when diff == 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - Asserting rst_n low immediately forces state IDLE, bit counter 0, borrow FF 0 and internal shift registers 0.
  - Outputs during and after reset: busy=0, done=0, diff=0, borrow_out=0, overflow=0, zero=0.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 on an edge: latch a and b into shift registers sa and sb, clear borrow FF, set cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each edge:
  - d = sa[0] ^ sb[0] ^ bw.
  - bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw).
  - Shift sa and sb right by one.
  - Shift d into the MSB of the internal result register sr, which shifts right.
  - cnt increments. On the edge where cnt == WIDTH-1, the final bit is processed and the state moves to DONE.
- Output registers load on that final RUN edge:
  - diff = final sr.
  - borrow_out = final bw.
  - zero = (final sr == 0).
  - overflow = (a_msb != b_msb) && (diff_msb != a_msb). The operand MSBs are held in dedicated registers captured at accept.
- Output stability: diff and the flags hold their previous values for the whole of RUN and change only at DONE entry.
- Latency:
  - Start is accepted on edge k.
  - Bits are processed on edges k+1..k+WIDTH.
  - done=1 and the new results are visible in the cycle after edge k+WIDTH.
  - Total latency is WIDTH cycles from the accept edge.
- DONE (busy=0, done=1 for exactly one cycle):
  - If start=1: accept the new operands as in IDLE and go to RUN (back-to-back, no idle gap). Outputs hold until that new operation completes.
  - Otherwise go to IDLE.
- busy is high in RUN only; done is high in DONE only.
- start is ignored in RUN. a and b may change freely after the accepting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter width is clog2(WIDTH).

Test Plan:
- WIDTH=8, a=5, b=3, start pulse -> after 8 cycles done=1 for 1 cycle, diff=0x02, borrow_out=0, overflow=0, zero=0; busy high for exactly 8 cycles.
- a=3, b=5 -> diff=0xFE, borrow_out=1, overflow=0, zero=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- a=0xA5, b=0xA5 -> diff=0x00, zero=1, borrow_out=0. Then a=0x00, b=0xFF -> diff=0x01, borrow_out=1, overflow=0.
- Start held high with new operands during RUN, a/b toggled every cycle -> result reflects only the accepted operands. Start on the DONE cycle (a=0x10, b=0x01) -> busy rises on the next cycle, and diff=0x0F appears 8 cycles later.
- rst_n pulsed low asynchronously mid-RUN at cnt=4 -> all outputs 0 immediately, no done pulse; a fresh start afterwards gives a correct result.
- Randomized sweep, WIDTH=8 and WIDTH=13, 1000 operand pairs -> diff, borrow_out, overflow and zero match a reference model; done occurs exactly WIDTH cycles after each accept.
